vertex_xform_stream: RTL and testbench

Parametrised streaming 4x4 fixed-point vertex transform with ready/valid handshakes on both sides, a double-buffered matrix updated at vertex boundaries, and frame-end marker propagation. It sits between the vertex source (test-vector loader or DMA) and the rasteriser, and succeeds the fixed-width, handshake-less `vertex_processor_rtl`. Vertices enter and leave as four serial components (x, y, z, w).

---
 rtl/vertex_xform_stream.sv | 181 ++++++++++++++++++
 tb/tb_vertex_xform_stream.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_xform_stream.sv
// Streaming 4x4 fixed-point vertex transform: 4 serial components in, 4 transformed rows out.
// Latency: row 0 one compute cycle after the w beat; rows 1..3 back-to-back. Backpressure: out_ready stalls EMIT, in_ready low until all rows drain.
// Optional clamping of results behind VERTEX_XFORM_SAT_EN (default: two's-complement wrap, out_sat tied low).
module vertex_xform_stream #(
    parameter int M = 11,
    parameter int N = 7,
    parameter int W = M + N
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mtx_wr_en,
    input  logic [3:0]          mtx_wr_addr,
    input  logic signed [W-1:0] mtx_wr_data,
    input  logic                mtx_commit,
    output logic                mtx_pending,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic signed [M-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    output logic                out_sat,
    input  logic                out_ready
);

    localparam int ACC_W = 2 * W + 2;
    localparam logic signed [W-1:0] ONE = W'(1 <<< N);

    typedef enum logic {ST_LOAD, ST_EMIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_cnt;
    logic [1:0]            r_row;
    logic                  r_last;
    logic signed [W-1:0]   r_vec [4];
    logic signed [W-1:0]   r_shadow [16];
    logic signed [W-1:0]   r_active [16];
    logic signed [W-1:0]   w_shadow_nxt [16];
    logic                  r_pending;
    logic                  r_out_vld;
    logic                  r_out_last;
    logic                  r_out_sat;
    logic signed [M-1:0]   r_out_dat;

    logic                  w_in_acc;
    logic                  w_out_acc;
    logic                  w_swap;
    logic                  w_calc;
    logic [1:0]            w_calc_row;
    logic signed [2*W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [M-1:0]   w_res;
    logic                  w_sat;

    assign w_in_acc   = in_valid && (r_state == ST_LOAD);
    assign w_out_acc  = r_out_vld && out_ready;
    // Only swap between vertices so every row of a vertex sees the same matrix.
    assign w_swap     = r_pending && (r_state == ST_LOAD) && (r_cnt == 2'd0);
    // First EMIT cycle computes row 0; afterwards the next row is computed as the current one leaves.
    assign w_calc     = (r_state == ST_EMIT) && (!r_out_vld || (out_ready && (r_row != 2'd3)));
    assign w_calc_row = r_out_vld ? (r_row + 2'd1) : 2'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (w_in_acc && (r_cnt == 2'd3)) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_out_acc && (r_row == 2'd3)) w_state_nxt = ST_LOAD;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
        end
        if (mtx_wr_en) begin
            w_shadow_nxt[mtx_wr_addr] = mtx_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= ((i % 5) == 0) ? ONE : '0;
                r_active[i] <= ((i % 5) == 0) ? ONE : '0;
            end
            r_pending <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
                if (w_swap) begin
                    r_active[i] <= w_shadow_nxt[i];
                end
            end
            r_pending <= w_swap ? 1'b0 : (r_pending | mtx_commit);
        end
    end

    always_comb begin
        w_acc  = '0;
        w_prod = '0;
        for (int c = 0; c < 4; c++) begin
            w_prod = r_active[{w_calc_row, 2'(c)}] * r_vec[c];
            w_acc  = w_acc + ACC_W'(w_prod);
        end
        w_shift = w_acc >>> N;
    end

`ifdef VERTEX_XFORM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 <<< (M - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 <<< (M - 1)));

    always_comb begin
        w_res = w_shift[M-1:0];
        w_sat = 1'b0;
        if (w_shift > SAT_HI) begin
            w_res = M'(SAT_HI);
            w_sat = 1'b1;
        end else if (w_shift < SAT_LO) begin
            w_res = M'(SAT_LO);
            w_sat = 1'b1;
        end
    end
`else
    assign w_res = w_shift[M-1:0];
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 2'd0;
            r_row      <= 2'd0;
            r_last     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_last <= 1'b0;
            r_out_sat  <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_vec[c] <= '0;
            end
        end else begin
            if (w_in_acc) begin
                r_vec[r_cnt] <= in_data;
                r_cnt        <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_last <= in_last;
                end
            end
            if (w_calc) begin
                r_out_dat  <= w_res;
                r_out_sat  <= w_sat;
                r_out_last <= r_last && (w_calc_row == 2'd3);
                r_row      <= w_calc_row;
                r_out_vld  <= 1'b1;
            end else if (w_out_acc) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
                r_row      <= 2'd0;
            end
        end
    end

    assign in_ready    = (r_state == ST_LOAD);
    assign out_valid   = r_out_vld;
    assign out_data    = r_out_dat;
    assign out_last    = r_out_last;
    assign out_sat     = r_out_sat;
    assign mtx_pending = r_pending;

endmodule

// File: tb/tb_vertex_xform_stream.sv
// Scoreboard bench for vertex_xform_stream: directed cases plus randomized vertices, matrices and backpressure.
module tb_vertex_xform_stream;

    localparam int M = 11;
    localparam int N = 7;
    localparam int W = M + N;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                mtx_wr_en = 1'b0;
    logic [3:0]          mtx_wr_addr = '0;
    logic signed [W-1:0] mtx_wr_data = '0;
    logic                mtx_commit = 1'b0;
    logic                mtx_pending;
    logic signed [W-1:0] in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic signed [M-1:0] out_data;
    logic                out_valid;
    logic                out_last;
    logic                out_sat;
    logic                out_ready = 1'b1;

    vertex_xform_stream #(.M(M), .N(N), .W(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .mtx_wr_en(mtx_wr_en), .mtx_wr_addr(mtx_wr_addr), .mtx_wr_data(mtx_wr_data),
        .mtx_commit(mtx_commit), .mtx_pending(mtx_pending),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_sat(out_sat),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int d; bit l; bit s;} exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int or_mode = 0;
    int n_pop = 0;
    int m_shadow[16];
    int m_active[16];
    int m_pend_mat[16];
    bit m_pend = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: row r of A*v in fixed point, floor division by 2^N, then clamp or wrap to M bits.
    function automatic void model_row(input int mat[16], input int v[4], input int r,
                                      output int res, output bit sat);
        longint acc = 0;
        longint q;
        longint lim = longint'(1) << (M - 1);
        for (int c = 0; c < 4; c++) acc += longint'(mat[r*4+c]) * longint'(v[c]);
        q = acc / (longint'(1) << N);
        if (acc < 0 && q * (longint'(1) << N) != acc) q = q - 1;
        sat = 0;
`ifdef VERTEX_XFORM_SAT_EN
        if (q > lim - 1) begin q = lim - 1; sat = 1; end
        else if (q < -lim) begin q = -lim; sat = 1; end
`else
        q = q % (2 * lim);
        if (q < 0) q += 2 * lim;
        if (q >= lim) q -= 2 * lim;
`endif
        res = int'(q);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i] = ((i % 5) == 0) ? (1 << N) : 0;
            m_active[i] = m_shadow[i];
        end
        m_pend = 0;
    endtask

    task automatic wr(input int a, input int d);
        mtx_wr_en = 1; mtx_wr_addr = 4'(a); mtx_wr_data = W'(d);
        tick();
        mtx_wr_en = 0;
        m_shadow[a] = d;
    endtask

    task automatic commit();
        mtx_commit = 1;
        tick();
        mtx_commit = 0;
        m_pend = 1;
        m_pend_mat = m_shadow;
    endtask

    task automatic wait_no_pend();
        int t = 0;
        while (mtx_pending === 1'b1 && t < 1000) begin tick(); t++; end
        if (t >= 1000) chk("pending_timeout", 1, 0);
    endtask

    task automatic put(input int d, input bit last);
        int t = 0;
        bit done = 0;
        bit rdy;
        in_valid = 1; in_data = W'(d); in_last = last;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            t++;
            if (rdy) done = 1;
            else if (t > 1000) begin chk("in_ready_timeout", 0, 1); done = 1; end
        end
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic send(input int v[4], input bit last, input int commit_at);
        int mat[16];
        int res;
        bit sat;
        exp_t e;
        if (m_pend) begin m_active = m_pend_mat; m_pend = 0; end
        mat = m_active;
        for (int c = 0; c < 4; c++) begin
            put(v[c], (c == 3) ? last : bit'($urandom_range(0, 1)));
            if (commit_at == c) commit();
        end
        for (int r = 0; r < 4; r++) begin
            model_row(mat, v, r, res, sat);
            e.d = res; e.s = sat; e.l = last && (r == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 3000) begin tick(); t++; end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic int rnd_s(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_sat"}, out_sat, 0);
        chk({tag, "_mtx_pending"}, mtx_pending, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 0;
            endcase
        end
    end

    // Monitor: pops on every output handshake and checks hold-stability while stalled.
    logic signed [M-1:0] p_dat;
    logic p_last, p_sat;
    bit stall_prev = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 0;
            end else begin
                if (out_valid && !out_ready) begin
                    if (stall_prev) begin
                        chk("stall_data_stable", out_data, p_dat);
                        chk("stall_last_stable", out_last, p_last);
                        chk("stall_sat_stable", out_sat, p_sat);
                        chk("stall_in_ready", in_ready, 0);
                    end
                    stall_prev = 1;
                    p_dat = out_data; p_last = out_last; p_sat = out_sat;
                end else begin
                    stall_prev = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("row_data", out_data, e.d);
                        chk("row_last", out_last, e.l);
                        chk("row_sat", out_sat, e.s);
                    end
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int v[4];
        int base;
        int t;
        model_reset();
        #3;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        reset_n = 1;
        tick();

        // Identity matrix, exact cycle placement of the four rows.
        v = '{10, -20, 30, 1};
        send(v, 0, -1);
        @(negedge clk); chk("t1_compute_gap", out_valid, 0);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); chk("t1_row_valid", out_valid, 1);
        end
        @(negedge clk); chk("t1_after_rows", out_valid, 0);
        tick();
        drain();

        // Floor behaviour for positive and negative accumulations.
        wr(0, 83); wr(1, -48); wr(2, -83);
        commit();
        v = '{100, 0, 0, 1};
        send(v, 0, -1);
        drain(); wait_no_pend();
        wr(0, -83); wr(1, 0); wr(2, 0);
        commit();
        send(v, 0, -1);
        drain(); wait_no_pend();

        // Overflow: clamp or wrap depending on build.
        wr(0, 256); wr(5, 256); wr(10, 256); wr(15, 256);
        commit();
        v = '{1500, -1500, 3, -7};
        send(v, 0, -1);
        drain(); wait_no_pend();

        // Five-cycle stall on row 1.
        base = n_pop;
        v = '{5, 6, 7, 8};
        send(v, 0, -1);
        t = 0;
        do begin @(posedge clk); t++; end while (n_pop < base + 1 && t < 200);
        or_mode = 2;
        repeat (5) @(posedge clk);
        or_mode = 0;
        #1;
        drain();

        // Commit after the y beat: current vertex keeps the old matrix.
        wait_no_pend();
        for (int i = 0; i < 16; i++) wr(i, rnd_s(300));
        v = '{rnd_s(2000), rnd_s(2000), rnd_s(2000), rnd_s(2000)};
        send(v, 0, 1);
        @(negedge clk); chk("t5_pending_set", mtx_pending, 1);
        tick();
        drain();
        tick();
        chk("t5_pending_clear", mtx_pending, 0);
        v = '{rnd_s(2000), rnd_s(2000), rnd_s(2000), rnd_s(2000)};
        send(v, 0, -1);
        drain();

        // Frame of three vertices, then a reset in the middle of the next frame.
        for (int k = 0; k < 3; k++) begin
            v = '{rnd_s(2000), rnd_s(2000), rnd_s(2000), rnd_s(2000)};
            send(v, k == 2, -1);
        end
        drain();
        v = '{rnd_s(2000), rnd_s(2000), rnd_s(2000), rnd_s(2000)};
        send(v, 0, -1);
        drain();
        put(11, 0);
        put(22, 0);
        #2;
        reset_n = 0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_idle", out_valid, 0);
        end
        v = '{7, -3, 5, 2};
        send(v, 0, -1);
        drain();

        // Randomized vertices, matrices and backpressure.
        or_mode = 1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_no_pend();
                repeat ($urandom_range(1, 6)) begin
                    if ($urandom_range(0, 1) == 0) wr(int'($urandom_range(0, 15)), rnd_s(256));
                    else wr(int'($urandom_range(0, 15)), rnd_s(131071));
                end
                if ($urandom_range(0, 1) == 0) commit();
            end
            if ($urandom_range(0, 1) == 0)
                v = '{rnd_s(3000), rnd_s(3000), rnd_s(3000), rnd_s(3000)};
            else
                v = '{rnd_s(131071), rnd_s(131071), rnd_s(131071), rnd_s(131071)};
            send(v, bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        drain();
        or_mode = 0;
        tick();
        chk("final_out_valid", out_valid, 0);
        chk("final_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
